// File: rtl/sim_sweep_sequencer.sv
// sim_sweep_sequencer: tick-gated, multi-lane raster sweep of the simulation grid.
// Each lane owns a horizontal stripe of ROWS rows; all lanes share column x and row offset
// and step together through SETTLE -> WRITE -> ADVANCE for every cell.
// Optional build macro: SWEEP_SERPENTINE_EN selects boustrophedon (serpentine) scan order.
module sim_sweep_sequencer #(
  parameter int unsigned X_BITS        = 8,
  parameter int unsigned Y_BITS        = 7,
  parameter int unsigned X_MAX         = 159,
  parameter int unsigned Y_MAX         = 119,
  parameter int unsigned LANES         = 2,
  parameter int unsigned TICK_DIV      = 50000000,
  parameter int unsigned SETTLE_CYCLES = 2
) (
  input  logic                      clk,
  input  logic                      RESET_SIM,
  input  logic                      setup_done,
  input  logic                      run_en,
  input  logic                      step_req,
  input  logic                      wr_ack,
  output logic [LANES*X_BITS-1:0]   loc_x,
  output logic [LANES*Y_BITS-1:0]   loc_y,
  output logic                      write_flag,
  output logic                      game_tick,
  output logic                      sweep_busy,
  output logic                      sweep_done,
  output logic                      sweep_overrun,
  output logic [2:0]                state_o
);

  localparam int unsigned ROWS = (Y_MAX + 1) / LANES;
  localparam int unsigned TW   = $clog2(TICK_DIV);
  localparam int unsigned SW   = $clog2(SETTLE_CYCLES + 1);

  typedef enum logic [2:0] {
    S_SETUP   = 3'd0,
    S_IDLE    = 3'd1,
    S_SETTLE  = 3'd2,
    S_WRITE   = 3'd3,
    S_ADVANCE = 3'd4,
    S_PAUSED  = 3'd5
  } state_t;

  state_t            state_q, state_d;
  logic [TW-1:0]     tick_q, tick_d;
  logic [SW-1:0]     settle_q, settle_d;
  logic [X_BITS-1:0] x_q, x_d;
  logic [Y_BITS-1:0] off_q, off_d;
  logic              single_q, single_d;
  logic              done_d;
  logic              row_end, last_cell;
  logic [X_BITS-1:0] x_step, x_row;

`ifdef SWEEP_SERPENTINE_EN
  // Serpentine order: odd row offsets scan right-to-left.
  always_comb begin
    row_end = off_q[0] ? (x_q == '0) : (x_q == X_BITS'(X_MAX));
    x_step  = off_q[0] ? (x_q - 1'b1) : (x_q + 1'b1);
    x_row   = off_q[0] ? '0 : X_BITS'(X_MAX);
  end
`else
  // Plain raster order: every row scans 0..X_MAX.
  always_comb begin
    row_end = (x_q == X_BITS'(X_MAX));
    x_step  = x_q + 1'b1;
    x_row   = '0;
  end
`endif

  assign last_cell = row_end && (off_q == Y_BITS'(ROWS - 1));

  // Next-state, sweep position and tick counter.
  always_comb begin
    state_d  = state_q;
    settle_d = settle_q;
    x_d      = x_q;
    off_d    = off_q;
    single_d = single_q;
    done_d   = 1'b0;
    tick_d   = tick_q;

    case (state_q)
      S_SETUP: begin
        if (setup_done) state_d = S_IDLE;
      end
      S_IDLE: begin
        if (!run_en) begin
          state_d = S_PAUSED;
        end else if (game_tick) begin
          state_d  = S_SETTLE;
          settle_d = '0;
          single_d = 1'b0;
        end
      end
      S_PAUSED: begin
        if (run_en) begin
          state_d = S_IDLE;
        end else if (step_req) begin
          state_d  = S_SETTLE;
          settle_d = '0;
          single_d = 1'b1;
        end
      end
      S_SETTLE: begin
        if (settle_q == SW'(SETTLE_CYCLES - 1)) state_d = S_WRITE;
        else                                    settle_d = settle_q + 1'b1;
      end
      S_WRITE: begin
        if (wr_ack) state_d = S_ADVANCE;
      end
      S_ADVANCE: begin
        if (last_cell) begin
          x_d     = '0;
          off_d   = '0;
          done_d  = 1'b1;
          state_d = (single_q || !run_en) ? S_PAUSED : S_IDLE;
        end else begin
          if (row_end) begin
            off_d = off_q + 1'b1;
            x_d   = x_row;
          end else begin
            x_d = x_step;
          end
          state_d  = S_SETTLE;
          settle_d = '0;
        end
      end
      default: state_d = S_SETUP;
    endcase

    // Loss of setup_done aborts everything back to the reset picture.
    if (state_q != S_SETUP && !setup_done) begin
      state_d  = S_SETUP;
      x_d      = '0;
      off_d    = '0;
      single_d = 1'b0;
      done_d   = 1'b0;
    end

    if (state_q == S_SETUP || state_d == S_SETUP) tick_d = '0;
    else if (tick_q == TW'(TICK_DIV - 1))         tick_d = '0;
    else                                          tick_d = tick_q + 1'b1;
  end

  // State, position and registered outputs.
  always_ff @(posedge clk or posedge RESET_SIM) begin
    if (RESET_SIM) begin
      state_q       <= S_SETUP;
      tick_q        <= '0;
      settle_q      <= '0;
      x_q           <= '0;
      off_q         <= '0;
      single_q      <= 1'b0;
      write_flag    <= 1'b0;
      game_tick     <= 1'b0;
      sweep_busy    <= 1'b0;
      sweep_done    <= 1'b0;
      sweep_overrun <= 1'b0;
      for (int k = 0; k < int'(LANES); k++)
        loc_y[k*Y_BITS +: Y_BITS] <= Y_BITS'(k * ROWS);
    end else begin
      state_q       <= state_d;
      tick_q        <= tick_d;
      settle_q      <= settle_d;
      x_q           <= x_d;
      off_q         <= off_d;
      single_q      <= single_d;
      write_flag    <= (state_d == S_WRITE);
      game_tick     <= (tick_d == TW'(TICK_DIV - 1));
      sweep_busy    <= (state_d == S_SETTLE) || (state_d == S_WRITE) || (state_d == S_ADVANCE);
      sweep_done    <= done_d;
      sweep_overrun <= sweep_overrun | (game_tick & sweep_busy);
      for (int k = 0; k < int'(LANES); k++)
        loc_y[k*Y_BITS +: Y_BITS] <= Y_BITS'(k * ROWS) + off_d;
    end
  end

  assign loc_x   = {LANES{x_q}};
  assign state_o = state_q;

endmodule

// File: tb/tb_sim_sweep_sequencer.sv
// Bench for sim_sweep_sequencer on a 4x4 grid, two lanes, 64-cycle tick, 2 settle cycles.
// Expected write order comes from a cell-index model of the sweep.
module tb_sim_sweep_sequencer;

  localparam int XB = 8;
  localparam int YB = 7;
  localparam int XM = 3;
  localparam int YM = 3;
  localparam int L  = 2;
  localparam int TD = 64;
  localparam int SC = 2;
  localparam int ROWS = (YM + 1) / L;
  localparam int CELLS = (XM + 1) * ROWS;

  logic clk = 1'b0;
  logic RESET_SIM = 1'b1;
  logic setup_done = 1'b0, run_en = 1'b0, step_req = 1'b0, wr_ack = 1'b0;
  logic [L*XB-1:0] loc_x;
  logic [L*YB-1:0] loc_y;
  logic write_flag, game_tick, sweep_busy, sweep_done, sweep_overrun;
  logic [2:0] state_o;

  int vec  = 0;
  int errs = 0;

  sim_sweep_sequencer #(
    .X_BITS(XB), .Y_BITS(YB), .X_MAX(XM), .Y_MAX(YM), .LANES(L),
    .TICK_DIV(TD), .SETTLE_CYCLES(SC)
  ) dut (
    .clk(clk), .RESET_SIM(RESET_SIM), .setup_done(setup_done), .run_en(run_en),
    .step_req(step_req), .wr_ack(wr_ack), .loc_x(loc_x), .loc_y(loc_y),
    .write_flag(write_flag), .game_tick(game_tick), .sweep_busy(sweep_busy),
    .sweep_done(sweep_done), .sweep_overrun(sweep_overrun), .state_o(state_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vec++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Cell i of a sweep: row offset i/(XM+1), position along the row i%(XM+1).
  function automatic int exp_x(input int i);
    int p = i % (XM + 1);
`ifdef SWEEP_SERPENTINE_EN
    if (((i / (XM + 1)) % 2) == 1) return XM - p;
`endif
    return p;
  endfunction

  function automatic logic [63:0] exp_lx(input int i);
    logic [63:0] v = '0;
    for (int k = 0; k < L; k++) v = v | (64'(exp_x(i)) << (k * XB));
    return v;
  endfunction

  function automatic logic [63:0] exp_ly(input int i);
    logic [63:0] v = '0;
    for (int k = 0; k < L; k++) v = v | (64'(k * ROWS + i / (XM + 1)) << (k * YB));
    return v;
  endfunction

  task automatic wait_tick(input string tag, output int n);
    n = 0;
    while (!game_tick && n < 300) begin
      step();
      n++;
    end
    chk({tag, "_tick_seen"}, 64'(game_tick), 64'd1);
  endtask

  // Drives wr_ack and checks writes from the first SETTLE cycle until sweep_done.
  // mode 0: ack tied 1; mode 1: random ack (at most 2 stall cycles); mode 2: first write stalled.
  task automatic run_sweep(input int mode, input int stall, input bit drop_run,
                           input string tag, output int first_len);
    int idx = 0, cyc = 0, hi = 0, rises = 0;
    bit prev_wf = 1'b0, done = 1'b0;
    logic [L*XB-1:0] hx = '0;
    first_len = 0;
    while (!done && cyc < 3000) begin
      if (write_flag) begin
        if (!prev_wf) begin
          rises++;
          hi = 0;
          hx = loc_x;
          chk({tag, "_loc_x"}, 64'(loc_x), exp_lx(idx));
          chk({tag, "_loc_y"}, 64'(loc_y), exp_ly(idx));
        end else begin
          chk({tag, "_loc_x_hold"}, 64'(loc_x), 64'(hx));
        end
        hi++;
      end
      case (mode)
        0:       wr_ack = 1'b1;
        1:       wr_ack = (hi >= 3) ? 1'b1 : 1'($urandom_range(0, 1));
        default: wr_ack = !(idx == 0 && hi <= stall);
      endcase
      if (drop_run && idx == CELLS / 2) run_en = 1'b0;
      if (write_flag && wr_ack) begin
        if (idx == 0) first_len = hi;
        idx++;
      end
      prev_wf = write_flag;
      if (sweep_done) done = 1'b1;
      else begin
        step();
        cyc++;
      end
    end
    chk({tag, "_done_seen"}, 64'(done), 64'd1);
    chk({tag, "_writes"}, 64'(idx), 64'(CELLS));
    chk({tag, "_wf_pulses"}, 64'(rises), 64'(CELLS));
    if (mode == 0) chk({tag, "_sweep_len"}, 64'(cyc), 64'(CELLS * (SC + 2)));
  endtask

  initial begin
    int n, cnt, flen, w;

    // Reset picture.
    step(); step();
    chk("rst_state", 64'(state_o), 64'd0);
    chk("rst_loc_x", 64'(loc_x), 64'd0);
    chk("rst_loc_y", 64'(loc_y), 64'(2 << YB));
    chk("rst_flags", 64'({write_flag, game_tick, sweep_busy, sweep_done, sweep_overrun}), 64'd0);
    RESET_SIM = 1'b0;

    // Held in SETUP: no ticks.
    cnt = 0;
    for (int i = 0; i < 200; i++) begin
      if (game_tick) cnt++;
      step();
    end
    chk("setup_no_tick", 64'(cnt), 64'd0);
    chk("setup_state", 64'(state_o), 64'd0);

    // Free-run sweep with wr_ack tied high.
    setup_done = 1'b1; run_en = 1'b1; wr_ack = 1'b1;
    step();
    chk("idle_state", 64'(state_o), 64'd1);
    wait_tick("first", n);
    chk("tick_latency", 64'(n), 64'(TD - 1));
    step();
    chk("sweep_start_state", 64'(state_o), 64'd2);
    chk("sweep_start_busy", 64'(sweep_busy), 64'd1);
    run_sweep(0, 0, 1'b0, "run0", flen);
    chk("run0_end_state", 64'(state_o), 64'd1);
    chk("run0_overrun", 64'(sweep_overrun), 64'd0);

    // step_req outside PAUSED is ignored; sweep_done is a single-cycle pulse.
    step_req = 1'b1;
    step();
    step_req = 1'b0;
    chk("done_pulse_width", 64'(sweep_done), 64'd0);
    chk("step_in_idle_state", 64'(state_o), 64'd1);
    chk("step_in_idle_busy", 64'(sweep_busy), 64'd0);

    // Random acknowledge timing.
    wait_tick("rnd", n);
    step();
    run_sweep(1, 0, 1'b0, "rnd", flen);
    chk("rnd_end_state", 64'(state_o), 64'd1);

    // First write stalled 5 cycles -> write_flag high 6 cycles.
    wait_tick("stall5", n);
    step();
    run_sweep(2, 5, 1'b0, "stall5", flen);
    chk("stall5_wf_len", 64'(flen), 64'd6);
    chk("stall5_overrun", 64'(sweep_overrun), 64'd0);

    // Long stall: next tick lands mid-sweep.
    wait_tick("ovr", n);
    step();
    run_sweep(2, 70, 1'b0, "ovr", flen);
    chk("ovr_flag", 64'(sweep_overrun), 64'd1);
    chk("ovr_end_state", 64'(state_o), 64'd1);
    chk("ovr_no_restart", 64'(sweep_busy), 64'd0);

    // run_en drops mid-sweep: sweep completes, then PAUSED.
    wr_ack = 1'b1;
    wait_tick("drop", n);
    step();
    run_sweep(0, 0, 1'b1, "drop", flen);
    chk("drop_end_state", 64'(state_o), 64'd5);

    // Paused: no writes; one step_req gives exactly one sweep.
    cnt = 0;
    for (int i = 0; i < 100; i++) begin
      if (write_flag) cnt++;
      step();
    end
    chk("paused_no_write", 64'(cnt), 64'd0);
    chk("paused_state", 64'(state_o), 64'd5);
    step_req = 1'b1;
    step();
    step_req = 1'b0;
    chk("single_start_state", 64'(state_o), 64'd2);
    run_sweep(1, 0, 1'b0, "single", flen);
    chk("single_end_state", 64'(state_o), 64'd5);
    cnt = 0;
    for (int i = 0; i < 100; i++) begin
      if (write_flag) cnt++;
      step();
    end
    chk("single_no_more_writes", 64'(cnt), 64'd0);

    // setup_done drop mid-sweep.
    run_en = 1'b1; wr_ack = 1'b1;
    step();
    wait_tick("abort", n);
    step();
    for (int i = 0; i < 10; i++) step();
    setup_done = 1'b0;
    step();
    chk("abort_state", 64'(state_o), 64'd0);
    chk("abort_wf", 64'(write_flag), 64'd0);
    chk("abort_loc_x", 64'(loc_x), 64'd0);
    chk("abort_loc_y", 64'(loc_y), 64'(2 << YB));
    chk("abort_busy", 64'(sweep_busy), 64'd0);
    cnt = 0;
    for (int i = 0; i < 5; i++) begin
      if (sweep_done) cnt++;
      step();
    end
    chk("abort_no_done", 64'(cnt), 64'd0);
    chk("abort_overrun_sticky", 64'(sweep_overrun), 64'd1);
    setup_done = 1'b1;
    step();
    chk("resume_state", 64'(state_o), 64'd1);
    wait_tick("resume", n);
    chk("resume_tick_latency", 64'(n), 64'(TD - 1));

    // Asynchronous reset during WRITE.
    step();
    w = 0;
    while (!write_flag && w < 10) begin
      step();
      w++;
    end
    chk("arst_wf_seen", 64'(write_flag), 64'd1);
    RESET_SIM = 1'b1;
    #1;
    chk("arst_wf", 64'(write_flag), 64'd0);
    chk("arst_state", 64'(state_o), 64'd0);
    chk("arst_loc_y", 64'(loc_y), 64'(2 << YB));
    chk("arst_overrun", 64'(sweep_overrun), 64'd0);
    chk("arst_busy", 64'(sweep_busy), 64'd0);
    step(); step();
    RESET_SIM = 1'b0;
    step();
    chk("post_arst_state", 64'(state_o), 64'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end

endmodule
